nibble_serial_add_ctrl: RTL and testbench

Sequencing controller that performs a wide (4×NIBBLES-bit) addition by time-multiplexing one shared external 4-bit ripple-carry adder, one nibble per clock, least-significant nibble first. It sits between a requester, which uses a valid/ready handshake, and the 4-bit adder datapath, whose ports it drives. Carry is registered between nibbles. The full-width sum and final carry are returned on a second valid/ready handshake.

---
 rtl/nibble_serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide adder built by sequencing one shared external
// 4-bit adder over NIBBLES slices, least-significant nibble first, with the
// carry registered between slices. Optional macro SUBTRACT_EN adds an op_sub
// input that turns the operation into A - B (two's complement, carry_out=1
// meaning no borrow).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   carry_in,
`ifdef SUBTRACT_EN
  input  logic                   op_sub,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [4*NIBBLES-1:0]   result_sum,
  output logic                   carry_out,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_run;
  logic            w_last;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [W-1:0]    w_sum_shift;
  logic            r_carry;
  logic            w_carry_init;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      w_b_nib;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == CW'(NIBBLES - 1));

  // New sum nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  generate
    if (NIBBLES == 1) begin : g_sum_one
      assign w_sum_shift = add_sum;
    end else begin : g_sum_multi
      assign w_sum_shift = {add_sum, r_sum[W-1:4]};
    end
  endgenerate

`ifdef SUBTRACT_EN
  logic r_sub;
  // Subtraction adds the inverted B nibble with a forced carry of 1 into nibble 0.
  assign w_b_nib      = r_sub ? ~r_b[3:0] : r_b[3:0];
  assign w_carry_init = op_sub ? 1'b1 : carry_in;

  // Operation mode is captured only at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_sub <= 1'b0;
    else if (w_accept) r_sub <= op_sub;
  end
`else
  assign w_b_nib      = r_b[3:0];
  assign w_carry_init = carry_in;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; handshake inputs are only honoured in their own state.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (result_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/sum shift registers, inter-nibble carry and nibble counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_carry <= w_carry_init;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_sum   <= w_sum_shift;
      r_carry <= add_cout;
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Outputs decode from state and registers only; the adder sees zeros outside RUN.
  always_comb begin
    start_ready  = (r_state == S_IDLE);
    busy         = (r_state != S_IDLE);
    result_valid = (r_state == S_DONE);
    result_sum   = r_sum;
    carry_out    = r_carry;
    add_a        = w_run ? r_a[3:0] : 4'h0;
    add_b        = w_run ? w_b_nib  : 4'h0;
    add_cin      = w_run ? r_carry  : 1'b0;
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: a 4-nibble and a 1-nibble
// instance, each connected to a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  // 4-nibble instance
  logic        s4_valid, s4_ready, cin4, sub4;
  logic [15:0] a4, b4, sum4;
  logic [3:0]  add_a4, add_b4, add_sum4;
  logic        add_cin4, add_cout4, rv4, rr4, co4, busy4;
  assign {add_cout4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

  nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .start_valid(s4_valid), .start_ready(s4_ready),
    .op_a(a4), .op_b(b4), .carry_in(cin4),
`ifdef SUBTRACT_EN
    .op_sub(sub4),
`endif
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_cout(add_cout4),
    .result_valid(rv4), .result_ready(rr4),
    .result_sum(sum4), .carry_out(co4), .busy(busy4)
  );

  // 1-nibble instance
  logic       s1_valid, s1_ready, cin1, sub1;
  logic [3:0] a1, b1, sum1;
  logic [3:0] add_a1, add_b1, add_sum1;
  logic       add_cin1, add_cout1, rv1, rr1, co1, busy1;
  assign {add_cout1, add_sum1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

  nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .start_valid(s1_valid), .start_ready(s1_ready),
    .op_a(a1), .op_b(b1), .carry_in(cin1),
`ifdef SUBTRACT_EN
    .op_sub(sub1),
`endif
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .result_valid(rv1), .result_ready(rr1),
    .result_sum(sum1), .carry_out(co1), .busy(busy1)
  );

  logic cin_log [4];
  int   lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request to the 4-nibble instance, then scramble the operand
  // inputs after acceptance; returns edges counted until result_valid.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, output int l);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = cin; sub4 = sub; s4_valid = 1'b1;
    l = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      l++;
      if (i == 0) begin
        s4_valid = 1'b0; a4 = 16'hDEAD; b4 = 16'hBEEF; cin4 = ~cin; sub4 = ~sub;
      end
      if (rv4) break;
      if (l <= 4) cin_log[l-1] = add_cin4;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    s4_valid = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; rr4 = 1;
    s1_valid = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; rr1 = 1;
    for (int i = 0; i < 4; i++) cin_log[i] = 1'b0;
    #12;

    // Reset state
    check("rst_start_ready", 32'(s4_ready), 32'd1);
    check("rst_result_valid", 32'(rv4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_sum", 32'(sum4), 32'd0);
    check("rst_carry_out", 32'(co4), 32'd0);
    check("rst_add_a", 32'(add_a4), 32'd0);
    check("rst_add_b", 32'(add_b4), 32'd0);
    check("rst_add_cin", 32'(add_cin4), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // 0x1234 + 0x0FCD
    run4(16'h1234, 16'h0FCD, 1'b0, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_sum", 32'(sum4), 32'h2201);
    check("t1_carry", 32'(co4), 32'd0);
    check("t1_busy", 32'(busy4), 32'd1);
    @(posedge clk); #1;
    check("t1_back_idle", 32'(s4_ready), 32'd1);
    check("t1_valid_drop", 32'(rv4), 32'd0);

    // 0xFFFF + 0x0001: carry ripples through every nibble
    run4(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_sum", 32'(sum4), 32'h0000);
    check("t2_carry", 32'(co4), 32'd1);
    check("t2_cin_n0", 32'(cin_log[0]), 32'd0);
    check("t2_cin_n1", 32'(cin_log[1]), 32'd1);
    check("t2_cin_n2", 32'(cin_log[2]), 32'd1);
    check("t2_cin_n3", 32'(cin_log[3]), 32'd1);
    check("t2_adder_quiet", 32'({add_a4, add_b4, add_cin4}), 32'd0);
    @(posedge clk); #1;

    // Backpressure: 0x00A5 + 0x005A + 1 = 0x0100
    rr4 = 1'b0;
    run4(16'h00A5, 16'h005A, 1'b1, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s4_valid = (k == 1); a4 = 16'h7777; b4 = 16'h1111;
      @(posedge clk); #1;
      check("bp_valid_hold", 32'(rv4), 32'd1);
      check("bp_sum_hold", 32'(sum4), 32'h0100);
      check("bp_carry_hold", 32'(co4), 32'd0);
      check("bp_start_ready", 32'(s4_ready), 32'd0);
    end
    @(negedge clk); s4_valid = 1'b0; rr4 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(s4_ready), 32'd1);
    check("bp_release_valid", 32'(rv4), 32'd0);
    check("bp_release_busy", 32'(busy4), 32'd0);

    // Reset in the middle of RUN nibble 2
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h0FCD; cin4 = 1'b0; s4_valid = 1'b1;
    @(posedge clk); #1; s4_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_add_a_n2", 32'(add_a4), 32'h2);
    #2; reset_n = 1'b0; #1;
    check("mid_rst_ready", 32'(s4_ready), 32'd1);
    check("mid_rst_valid", 32'(rv4), 32'd0);
    check("mid_rst_busy", 32'(busy4), 32'd0);
    check("mid_rst_sum", 32'(sum4), 32'd0);
    check("mid_rst_carry", 32'(co4), 32'd0);
    check("mid_rst_adder", 32'({add_a4, add_b4, add_cin4}), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("mid_no_pulse", 32'(rv4), 32'd0);
    end
    run4(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd5);
    check("post_rst_sum", 32'(sum4), 32'h0002);
    check("post_rst_carry", 32'(co4), 32'd0);
    @(posedge clk); #1;

`ifdef SUBTRACT_EN
    // 5 - 7 wraps with borrow; 7 - 5 has no borrow
    run4(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    check("sub1_sum", 32'(sum4), 32'hFFFE);
    check("sub1_carry", 32'(co4), 32'd0);
    @(posedge clk); #1;
    run4(16'h0007, 16'h0005, 1'b0, 1'b1, lat);
    check("sub2_sum", 32'(sum4), 32'h0002);
    check("sub2_carry", 32'(co4), 32'd1);
    @(posedge clk); #1;
`endif

    // Single-nibble instance: 9 + 8 + 1 = 0x12
    @(negedge clk);
    a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1; sub1 = 1'b0; s1_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 0) begin s1_valid = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0; end
      if (rv1) break;
    end
    check("n1_latency", 32'(lat), 32'd2);
    check("n1_sum", 32'(sum1), 32'h2);
    check("n1_carry", 32'(co1), 32'd1);
    @(posedge clk); #1;
    check("n1_back_idle", 32'(s1_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
